// File: rtl/led_blink_queue.sv
// Queued LED blinker: each request produces one ON pulse followed by a mandatory gap.
// Requests that arrive while a blink is in progress are counted and replayed back-to-back.
module led_blink_queue #(
  parameter int   p_on_cycles    = 1000,
  parameter int   p_off_cycles   = 1000,
  parameter int   p_max_pending  = 7,
  parameter logic p_active_level = 1'b1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_trig,
  input  logic                               i_clr_ovf,
  output logic                               o_led,
  output logic                               o_busy,
  output logic [$clog2(p_max_pending+1)-1:0] o_pending,
  output logic                               o_overflow
);

  localparam int c_max_cyc = (p_on_cycles > p_off_cycles) ? p_on_cycles : p_off_cycles;
  localparam int c_cw      = $clog2(c_max_cyc + 1);
  localparam int c_pw      = $clog2(p_max_pending + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } t_state;

  t_state            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic              r_led;
  logic              r_busy;
  logic [c_pw-1:0]   r_pending;
  logic              r_ovf;

  logic w_on_done;
  logic w_gap_done;
  logic w_req;
  logic w_start;
  logic w_full;

  assign w_on_done  = (r_cnt == c_cw'(p_on_cycles - 1));
  assign w_gap_done = (r_cnt == c_cw'(p_off_cycles - 1));
  assign w_req      = i_trig || (r_pending != '0);
  assign w_full     = (r_pending == c_pw'(p_max_pending));
  // A start happens from IDLE, or on the last GAP cycle without passing through IDLE.
  assign w_start    = w_req && ((r_state == S_IDLE) || ((r_state == S_GAP) && w_gap_done));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_led     <= ~p_active_level;
      r_busy    <= 1'b0;
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_state <= S_ON;
            r_led   <= p_active_level;
            r_busy  <= 1'b1;
          end
        end
        S_ON: begin
          if (w_on_done) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_led   <= ~p_active_level;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_cnt <= '0;
            if (w_start) begin
              r_state <= S_ON;
              r_led   <= p_active_level;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_led   <= ~p_active_level;
          r_busy  <= 1'b0;
        end
      endcase

      // Queued requests are served first; a concurrent trigger then takes the freed slot.
      if (w_start && (r_pending != '0)) begin
        if (!i_trig) begin
          r_pending <= r_pending - c_pw'(1);
        end
      end else if (!w_start && i_trig && !w_full) begin
        r_pending <= r_pending + c_pw'(1);
      end

      if (i_trig && !w_start && w_full) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_led      = r_led;
  assign o_busy     = r_busy;
  assign o_pending  = r_pending;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_led_blink_queue.sv
// Directed bench for led_blink_queue (on=4, off=3, max_pending=2), with an
// active-low instance sharing the same stimulus.
module tb_led_blink_queue;

  logic       clk;
  logic       i_rst;
  logic       i_trig;
  logic       i_clr_ovf;
  logic       led1, busy1, ovf1;
  logic [1:0] pend1;
  logic       led0, busy0, ovf0;
  logic [1:0] pend0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  led_blink_queue #(
    .p_on_cycles(4), .p_off_cycles(3), .p_max_pending(2), .p_active_level(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_trig(i_trig), .i_clr_ovf(i_clr_ovf),
    .o_led(led1), .o_busy(busy1), .o_pending(pend1), .o_overflow(ovf1)
  );

  led_blink_queue #(
    .p_on_cycles(4), .p_off_cycles(3), .p_max_pending(2), .p_active_level(1'b0)
  ) dut_lo (
    .i_clk(clk), .i_rst(i_rst), .i_trig(i_trig), .i_clr_ovf(i_clr_ovf),
    .o_led(led0), .o_busy(busy0), .o_pending(pend0), .o_overflow(ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic do_reset();
    i_rst     = 1'b1;
    i_trig    = 1'b1;
    i_clr_ovf = 1'b0;
    tick();
    tick();
    check("rst_led",   int'(led1),  0);
    check("rst_led_lo", int'(led0), 1);
    check("rst_busy",  int'(busy1), 0);
    check("rst_pend",  int'(pend1), 0);
    check("rst_ovf",   int'(ovf1),  0);
    i_rst  = 1'b0;
    i_trig = 1'b0;
    cyc    = 0;
  endtask

  // Scenarios: 1 single blink, 2 three queued, 3 overflow + clear,
  // 4 reset mid-blink, 5 trigger on last gap cycle, 6 trigger while full at a start.
  task automatic run_scn(input int id);
    bit e_led, e_busy, e_ovf;
    int e_pend;
    string s;
    do_reset();
    for (int c = 0; c <= 42; c++) begin
      e_led = 0; e_busy = 0; e_ovf = 0; e_pend = 0;
      i_trig = 0; i_clr_ovf = 0; i_rst = 0;
      case (id)
        1: begin
          i_trig = (c == 10);
          e_led  = in_rng(c, 11, 14);
          e_busy = in_rng(c, 11, 17);
        end
        2, 3: begin
          i_trig = (id == 2) ? in_rng(c, 10, 12) : in_rng(c, 10, 13);
          if (id == 3) i_clr_ovf = (c == 13) || (c == 20);
          e_led  = in_rng(c, 11, 14) || in_rng(c, 18, 21) || in_rng(c, 25, 28);
          e_busy = in_rng(c, 11, 31);
          e_pend = (c == 12) ? 1 : in_rng(c, 13, 17) ? 2 : in_rng(c, 18, 24) ? 1 : 0;
          e_ovf  = (id == 3) && in_rng(c, 14, 20);
        end
        4: begin
          i_trig = in_rng(c, 10, 11);
          i_rst  = (c == 12);
          e_led  = in_rng(c, 11, 12);
          e_busy = in_rng(c, 11, 12);
          e_pend = (c == 12) ? 1 : 0;
        end
        5: begin
          i_trig = (c == 10) || (c == 17);
          e_led  = in_rng(c, 11, 14) || in_rng(c, 18, 21);
          e_busy = in_rng(c, 11, 24);
        end
        default: begin
          i_trig = in_rng(c, 10, 12) || (c == 17);
          e_led  = in_rng(c, 11, 14) || in_rng(c, 18, 21) || in_rng(c, 25, 28) ||
                   in_rng(c, 32, 35);
          e_busy = in_rng(c, 11, 38);
          e_pend = (c == 12) ? 1 : in_rng(c, 13, 24) ? 2 : in_rng(c, 25, 31) ? 1 : 0;
        end
      endcase
      s = $sformatf("s%0d_", id);
      check({s, "led"},    int'(led1),  int'(e_led));
      check({s, "led_lo"}, int'(led0),  int'(!e_led));
      check({s, "busy"},   int'(busy1), int'(e_busy));
      check({s, "pend"},   int'(pend1), e_pend);
      check({s, "ovf"},    int'(ovf1),  int'(e_ovf));
      tick();
    end
  endtask

  initial begin
    i_rst = 1'b1; i_trig = 1'b0; i_clr_ovf = 1'b0;
    for (int k = 1; k <= 6; k++) run_scn(k);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
